ts_packet_gen: RTL

Synthesizable MPEG-2 TS transmitter that emits continuous 188-byte transport packets on a byte-wide valid/data interface, the same interface consumed by the input FIFOs and sync recovery of the QoS receive path. It generates sync byte, PID header, 4-bit continuity counter and a deterministic payload. It offers byte and packet gaps plus on-demand error injection: a corrupted sync byte, or a skipped continuity counter that the packet-loss counter counts as one lost packet. It is used as the stimulus source on the ingest ports and as an on-chip loopback generator.

---
 rtl/ts_pkg.sv | 27 ++
 rtl/ts_gap_timer.sv | 33 +++
 rtl/ts_packet_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ts_pkg.sv
// ts_pkg: constants and types shared by the TS packet generator, sync
// recovery and the packet-loss counter.
//   TS_SYNC_BYTE / TS_SYNC_ERR : good and deliberately corrupted sync byte
//   TS_PKT_LEN / TS_HDR_LEN    : packet length and header length in bytes
//   AFC_PAYLOAD                : adaptation-field control, payload only
//   ts_gen_state_t             : generator FSM states
package ts_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam logic [7:0] TS_SYNC_ERR  = 8'hB8;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         TS_HDR_LEN   = 4;
  localparam logic [1:0] AFC_PAYLOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BYTE = 2'd1,
    BGAP = 2'd2,
    PGAP = 2'd3
  } ts_gen_state_t;

  // Header byte 3: not scrambled, payload only, continuity counter.
  function automatic logic [7:0] ts_hdr_byte3(input logic [3:0] cc);
    return {2'b00, AFC_PAYLOAD, cc};
  endfunction

endpackage

// File: rtl/ts_gap_timer.sv
// ts_gap_timer: 8-bit loadable down-counter timing the idle cycles between
// bytes and between packets.
//   clk, rst : clock, synchronous active-high reset
//   i_load   : load i_value this cycle
//   i_value  : number of idle cycles to time
//   i_dec    : count down one idle cycle
//   o_done   : the current idle cycle is the last one of the gap
module ts_gap_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_value,
  input  logic       i_dec,
  output logic       o_done
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  // Loaded with N, the count reads N..1 across the N idle cycles; the cycle
  // reading 1 is the last one.
  assign o_done = (r_count <= 8'd1);

endmodule

// File: rtl/ts_packet_gen.sv
// ts_packet_gen: MPEG-2 transport stream packet generator.
// Emits 188-byte packets (sync, PID header, continuity counter, counting
// payload) with programmable byte and packet gaps and on-demand error
// injection (corrupted sync byte, skipped continuity counter).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   enable            : level, generate packets while high
//   pid_cfg           : PID of the next packet, 0 selects PID_DEFAULT
//   byte_gap, pkt_gap : idle cycles between bytes / after the last byte
//   drop_req          : pulse, skip one continuity counter value
//   sync_err_req      : pulse, corrupt the next sync byte
//   valid_out         : ts_data_out carries a byte this cycle
//   sync_out          : marks byte 0 of each packet
//   ts_data_out       : packet byte, held while valid_out is low
//   pkt_count         : packets fully emitted since reset
//   busy              : from the first byte to the end of the trailing gap
//   dbg_state         : current FSM state
// Stream handshake: valid-only. A byte is transferred in every cycle where
// valid_out is high; there is no ready, so the consumer must take it then.
module ts_packet_gen
  import ts_pkg::*;
#(
  parameter logic [12:0] PID_DEFAULT = 13'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [12:0] pid_cfg,
  input  logic [7:0]  byte_gap,
  input  logic [7:0]  pkt_gap,
  input  logic        drop_req,
  input  logic        sync_err_req,
  output logic        valid_out,
  output logic        sync_out,
  output logic [7:0]  ts_data_out,
  output logic [31:0] pkt_count,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int         PKT_LEN  = TS_PKT_LEN;
  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  // r_state describes what the registered outputs show in this cycle:
  // BYTE means byte r_idx is on ts_data_out.
  ts_gen_state_t r_state, w_next_state;
  logic [7:0]    r_idx, w_next_idx;
  logic          w_emit, w_pkt_start, w_pkt_done;
  logic          w_timer_load, w_timer_dec, w_timer_done;
  logic [7:0]    w_timer_val;

  logic [12:0]   r_pid;
  logic [7:0]    r_byte_gap, r_pkt_gap;
  logic [3:0]    r_cc, r_cc_next, w_pkt_cc;
  logic          r_pusi, r_pusi_pend;
  logic          r_drop_flag, r_sync_flag, w_drop_arm, w_sync_arm;
  logic [12:0]   w_pid_sel;
  logic [7:0]    w_byte;

  logic          r_valid, r_sync, r_busy;
  logic [7:0]    r_data;
  logic [31:0]   r_pkt_count;

  ts_gap_timer u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_timer_load),
    .i_value (w_timer_val),
    .i_dec   (w_timer_dec),
    .o_done  (w_timer_done)
  );

  // A request arriving in the cycle that decides byte 0 still reaches that
  // packet; one arriving while byte 0 is on the bus waits for the next.
  assign w_drop_arm = r_drop_flag | drop_req;
  assign w_sync_arm = r_sync_flag | sync_err_req;
  assign w_pkt_cc   = r_cc_next + {3'b000, w_drop_arm};
  assign w_pid_sel  = (pid_cfg == 13'd0) ? PID_DEFAULT : pid_cfg;

  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_next_idx   = r_idx;
    w_timer_load = 1'b0;
    w_timer_val  = r_byte_gap;
    w_timer_dec  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next_state = BYTE;
          w_emit       = 1'b1;
          w_next_idx   = 8'd0;
        end
      end
      BYTE: begin
        if (r_idx != LAST_IDX) begin
          if (r_byte_gap != 8'd0) begin
            w_next_state = BGAP;
            w_timer_load = 1'b1;
            w_timer_val  = r_byte_gap;
          end else begin
            w_emit     = 1'b1;
            w_next_idx = r_idx + 8'd1;
          end
        end else if (r_pkt_gap != 8'd0) begin
          w_next_state = PGAP;
          w_timer_load = 1'b1;
          w_timer_val  = r_pkt_gap;
        end else if (enable) begin
          w_emit     = 1'b1;
          w_next_idx = 8'd0;
        end else begin
          w_next_state = IDLE;
        end
      end
      BGAP: begin
        w_timer_dec = 1'b1;
        if (w_timer_done) begin
          w_next_state = BYTE;
          w_emit       = 1'b1;
          w_next_idx   = r_idx + 8'd1;
        end
      end
      PGAP: begin
        w_timer_dec = 1'b1;
        if (w_timer_done) begin
          if (enable) begin
            w_next_state = BYTE;
            w_emit       = 1'b1;
            w_next_idx   = 8'd0;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_pkt_start = w_emit && (w_next_idx == 8'd0);
  assign w_pkt_done  = (r_state == BYTE) && (r_idx == LAST_IDX);

  // Byte 0 is built from live inputs; bytes 1..3 use values captured with
  // byte 0, which are already registered by the time those bytes go out.
  always_comb begin
    w_byte = 8'h00;
    case (w_next_idx)
      8'd0:    w_byte = w_sync_arm ? TS_SYNC_ERR : TS_SYNC_BYTE;
      8'd1:    w_byte = {1'b0, r_pusi, 1'b0, r_pid[12:8]};
      8'd2:    w_byte = r_pid[7:0];
      8'd3:    w_byte = ts_hdr_byte3(r_cc);
      default: w_byte = w_next_idx - 8'(TS_HDR_LEN) + {4'd0, r_cc};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= 8'd0;
      r_pid       <= 13'd0;
      r_byte_gap  <= 8'd0;
      r_pkt_gap   <= 8'd0;
      r_cc        <= 4'd0;
      r_cc_next   <= 4'd0;
      r_pusi      <= 1'b0;
      r_pusi_pend <= 1'b1;
      r_drop_flag <= 1'b0;
      r_sync_flag <= 1'b0;
      r_valid     <= 1'b0;
      r_sync      <= 1'b0;
      r_data      <= 8'h00;
      r_busy      <= 1'b0;
      r_pkt_count <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != IDLE);

      if (w_emit) begin
        r_valid <= 1'b1;
        r_sync  <= (w_next_idx == 8'd0);
        r_data  <= w_byte;
        r_idx   <= w_next_idx;
      end else begin
        r_valid <= 1'b0;
        r_sync  <= 1'b0;
      end

      if (w_pkt_start) begin
        r_pid       <= w_pid_sel;
        r_byte_gap  <= byte_gap;
        r_pkt_gap   <= pkt_gap;
        r_cc        <= w_pkt_cc;
        r_cc_next   <= w_pkt_cc + 4'd1;
        r_pusi      <= r_pusi_pend;
        r_pusi_pend <= 1'b0;
        r_drop_flag <= 1'b0;
        r_sync_flag <= 1'b0;
      end else begin
        r_drop_flag <= w_drop_arm;
        r_sync_flag <= w_sync_arm;
        if ((w_next_state == IDLE) && (r_state != IDLE)) begin
          r_pusi_pend <= 1'b1;
        end
      end

      if (w_pkt_done) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign valid_out   = r_valid;
  assign sync_out    = r_sync;
  assign ts_data_out = r_data;
  assign pkt_count   = r_pkt_count;
  assign busy        = r_busy;
  assign dbg_state   = r_state;

endmodule
